// File: rtl/led_chaser_ctrl.sv
// Running-light position sequencer for a 4-to-16 LED decoder.
// Auto-advance from a prescaler, or single-step from a debounced push button.
module led_chaser_ctrl #(
  parameter int unsigned TICK_DIV  = 25_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       run,
  input  logic [1:0] mode,
  input  logic       step_n,
  output logic [3:0] idx,
  output logic       tick,
  output logic       dir
);

  localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_TC    = DW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    M_UP   = 2'b00,
    M_DOWN = 2'b01,
    M_PING = 2'b10,
    M_HOLD = 2'b11
  } mode_e;

  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] dbcnt_q, dbcnt_d;
  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          stab_dly_q;
  logic          press_q, press_d;
  logic [3:0]    idx_q, idx_d;
  logic          dir_q, dir_d;
  logic          tick_q, tick_d;
  logic          adv, ev;
  mode_e         mode_e_w;

  assign mode_e_w = mode_e'(mode);

  always_comb begin
    presc_d = '0;
    adv     = 1'b0;
    if (run) begin
      if (presc_q == PRESC_TC) adv = 1'b1;
      else                     presc_d = presc_q + 1'b1;
    end

    // Any agreeing sample restarts the debounce count.
    stable_d = stable_q;
    dbcnt_d  = '0;
    if (sync2_q != stable_q) begin
      if (dbcnt_q == DB_TC) stable_d = sync2_q;
      else                  dbcnt_d  = dbcnt_q + 1'b1;
    end

    // Press is taken from the registered stable history: falling edge only.
    press_d = stab_dly_q & ~stable_q;

    ev     = run ? adv : press_q;
    idx_d  = idx_q;
    dir_d  = dir_q;
    tick_d = 1'b0;
    if (ev) begin
      unique case (mode_e_w)
        M_UP: begin
          idx_d  = idx_q + 4'd1;
          dir_d  = 1'b0;
          tick_d = 1'b1;
        end
        M_DOWN: begin
          idx_d  = idx_q - 4'd1;
          dir_d  = 1'b1;
          tick_d = 1'b1;
        end
        M_PING: begin
          tick_d = 1'b1;
          if (!dir_q) begin
            if (idx_q == 4'd15) begin idx_d = 4'd14; dir_d = 1'b1; end
            else                      idx_d = idx_q + 4'd1;
          end else begin
            if (idx_q == 4'd0) begin idx_d = 4'd1; dir_d = 1'b0; end
            else                     idx_d = idx_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      presc_q    <= '0;
      dbcnt_q    <= '0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      stable_q   <= 1'b1;
      stab_dly_q <= 1'b1;
      press_q    <= 1'b0;
      idx_q      <= '0;
      dir_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      dbcnt_q    <= dbcnt_d;
      sync1_q    <= step_n;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      stab_dly_q <= stable_q;
      press_q    <= press_d;
      idx_q      <= idx_d;
      dir_q      <= dir_d;
      tick_q     <= tick_d;
    end
  end

  assign idx  = idx_q;
  assign dir  = dir_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_chaser_ctrl.sv
// Directed bench for led_chaser_ctrl with TICK_DIV=4, DB_CYCLES=8.
module tb_led_chaser_ctrl;

  logic       clk = 1'b0;
  logic       reset, run, step_n;
  logic [1:0] mode;
  logic [3:0] idx;
  logic       tick, dir;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] mode;
    int         cyc;
    logic [3:0] idx;
    logic       dir;
  } vec_t;

  vec_t vecs[$];

  led_chaser_ctrl #(.TICK_DIV(4), .DB_CYCLES(8)) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .run     (run),
    .mode    (mode),
    .step_n  (step_n),
    .idx     (idx),
    .tick    (tick),
    .dir     (dir)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Run v.cyc cycles; tick must appear on the last one only.
  task automatic apply(input vec_t v, input string name);
    int early;
    early = 0;
    mode  = v.mode;
    for (int k = 1; k <= v.cyc; k++) begin
      step();
      if (k < v.cyc && tick === 1'b1) early++;
    end
    chk({name, ".early"}, early, 0);
    chk({name, ".tick"},  tick,  1);
    chk({name, ".idx"},   idx,   v.idx);
    chk({name, ".dir"},   dir,   v.dir);
  endtask

  task automatic count_ticks(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (tick === 1'b1) cnt++;
    end
  endtask

  task automatic wait_press(input int n, output int first, output int cnt);
    first = -1;
    cnt   = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      if (tick === 1'b1) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
  endtask

  initial begin
    int cnt, first, misalign;

    for (int i = 1; i <= 16; i++) vecs.push_back('{2'b00, 4, 4'(i % 16), 1'b0});
    for (int i = 1; i <= 13; i++) vecs.push_back('{2'b00, 4, 4'(i), 1'b0});
    vecs.push_back('{2'b10, 4, 4'd14, 1'b0});
    vecs.push_back('{2'b10, 4, 4'd15, 1'b0});
    for (int i = 14; i >= 0; i--) vecs.push_back('{2'b10, 4, 4'(i), 1'b1});
    vecs.push_back('{2'b10, 4, 4'd1, 1'b0});
    vecs.push_back('{2'b01, 4, 4'd0, 1'b1});
    vecs.push_back('{2'b01, 4, 4'd15, 1'b1});

    reset = 1'b1; run = 1'b0; mode = 2'b00; step_n = 1'b1;
    step(); step();
    chk("rst.idx", idx, 0);
    chk("rst.dir", dir, 0);
    chk("rst.tick", tick, 0);

    reset = 1'b0; run = 1'b1;
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    mode = 2'b11;
    count_ticks(20, cnt);
    chk("hold.ticks", cnt, 0);
    chk("hold.idx", idx, 15);
    chk("hold.dir", dir, 1);

    run = 1'b0; mode = 2'b00;
    repeat (3) step();
    step_n = 1'b0;
    wait_press(30, first, cnt);
    chk("press.count", cnt, 1);
    chk("press.cycle", first, 12);
    chk("press.idx", idx, 0);
    chk("press.dir", dir, 0);
    step_n = 1'b1;
    count_ticks(20, cnt);
    chk("release.ticks", cnt, 0);

    cnt = 0;
    for (int r = 0; r < 3; r++) begin
      step_n = 1'b0;
      for (int k = 0; k < 3 + 2 * r; k++) begin step(); if (tick === 1'b1) cnt++; end
      step_n = 1'b1;
      for (int k = 0; k < 2; k++) begin step(); if (tick === 1'b1) cnt++; end
    end
    chk("bounce.ticks", cnt, 0);
    step_n = 1'b0;
    wait_press(20, first, cnt);
    chk("bounce.count", cnt, 1);
    chk("bounce.cycle", first, 12);
    chk("bounce.idx", idx, 1);
    step_n = 1'b1;
    repeat (20) step();

    run = 1'b1; step_n = 1'b0;
    cnt = 0; misalign = 0;
    for (int n = 1; n <= 24; n++) begin
      step();
      if (tick === 1'b1) begin
        cnt++;
        if (n % 4 != 0) misalign++;
      end
    end
    step_n = 1'b1;
    chk("runpress.ticks", cnt, 6);
    chk("runpress.align", misalign, 0);
    chk("runpress.idx", idx, 7);

    apply('{2'b00, 4, 4'd8,  1'b0}, "s6a");
    apply('{2'b00, 4, 4'd9,  1'b0}, "s6b");
    apply('{2'b00, 4, 4'd10, 1'b0}, "s6c");
    apply('{2'b01, 4, 4'd9,  1'b1}, "s6d");
    step(); step();
    reset = 1'b1;
    step();
    chk("midrst.idx", idx, 0);
    chk("midrst.dir", dir, 0);
    chk("midrst.tick", tick, 0);
    reset = 1'b0;
    apply('{2'b01, 4, 4'd15, 1'b1}, "postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
